// File: rtl/boot_pkg.sv
// Shared definitions for the byte-serial instruction-memory boot loader:
// FSM state encoding, word framing constants.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_LOAD = 3'd1,
    ST_CHK  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_W          = 32;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/boot_word_asm.sv
// Big-endian byte-to-word assembler: word_vld_o pulses combinationally with the
// last byte of each word; clr_i discards any partially assembled word.
module boot_word_asm
  import boot_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             byte_vld_i,
  input  logic [7:0]       byte_dat_i,
  output logic             word_vld_o,
  output logic [HDR_W-1:0] word_o
);

  logic [BCNT_W-1:0] cnt_q;
  logic [HDR_W-1:0]  sh_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else if (byte_vld_i) begin
      cnt_q <= cnt_q + 1'b1;
      sh_q  <= {sh_q[HDR_W-9:0], byte_dat_i};
    end
  end

  assign word_vld_o = byte_vld_i && !clr_i && (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));
  assign word_o     = {sh_q[HDR_W-9:0], byte_dat_i};

endmodule

// File: rtl/im_boot_loader.sv
// Framed program loader into instruction memory; holds the core in reset until loaded.
// Define BOOT_CHKSUM_EN to require a trailing 32-bit sum word after the data words.
module im_boot_loader
  import boot_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int DEPTH = 1 << AW;
  localparam logic [HDR_W-1:0] DEPTH_W = HDR_W'(DEPTH);

  state_t            state_q;
  logic [AW:0]       n_q;
  logic [AW:0]       word_cnt_q;
  logic [AW:0]       word_cnt_d;
  logic              im_we_q;
  logic [AW-1:0]     im_addr_q;
  logic [31:0]       im_wdata_q;
  logic              cpu_rst_q;
  logic              done_q;
  logic              err_q;
`ifdef BOOT_CHKSUM_EN
  logic [31:0]       sum_q;
`endif

  logic              accept;
  logic              word_vld;
  logic [HDR_W-1:0]  word;

  // A byte offered alongside start is refused so it cannot leak into the new frame.
  assign rx_ready   = !start && (state_q == ST_HDR || state_q == ST_LOAD || state_q == ST_CHK);
  assign accept     = rx_valid && rx_ready;
  assign word_cnt_d = word_cnt_q + 1'b1;

  boot_word_asm u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (start),
    .byte_vld_i (accept),
    .byte_dat_i (rx_data),
    .word_vld_o (word_vld),
    .word_o     (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_HDR;
      n_q        <= '0;
      word_cnt_q <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef BOOT_CHKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      im_we_q   <= 1'b0;
      cpu_rst_q <= !done_q;
      if (start) begin
        state_q    <= ST_HDR;
        n_q        <= '0;
        word_cnt_q <= '0;
        im_addr_q  <= '0;
        im_wdata_q <= '0;
        cpu_rst_q  <= 1'b1;
        done_q     <= 1'b0;
        err_q      <= 1'b0;
`ifdef BOOT_CHKSUM_EN
        sum_q      <= '0;
`endif
      end else if (word_vld) begin
        case (state_q)
          ST_HDR: begin
            if (word > DEPTH_W) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end else if (word == '0) begin
`ifdef BOOT_CHKSUM_EN
              state_q <= ST_CHK;
`else
              state_q <= ST_DONE;
              done_q  <= 1'b1;
`endif
            end else begin
              state_q <= ST_LOAD;
              n_q     <= word[AW:0];
            end
          end
          ST_LOAD: begin
            im_we_q    <= 1'b1;
            im_addr_q  <= word_cnt_q[AW-1:0];
            im_wdata_q <= word;
            word_cnt_q <= word_cnt_d;
`ifdef BOOT_CHKSUM_EN
            sum_q      <= sum_q + word;
            if (word_cnt_d == n_q) state_q <= ST_CHK;
`else
            if (word_cnt_d == n_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
`endif
          end
`ifdef BOOT_CHKSUM_EN
          ST_CHK: begin
            if (word == sum_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign cpu_rst  = cpu_rst_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = !(done_q || err_q);

endmodule

// File: tb/tb_im_boot_loader.sv
// Directed bench for im_boot_loader: framing, limits, restart, async reset.
module tb_im_boot_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          err;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];

  im_boot_loader #(.AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wa.push_back(im_addr);
      wd.push_back(im_wdata);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called and returns at a falling edge; byte is consumed at the rising edge in between.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int w;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    #1;
    w = 0;
    while (rx_ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (rx_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: rx_ready=%b required 1", rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++)
      send_byte(w[31-8*i -: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wa.delete();
    wd.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #3;
    checks++;
    if ({im_we, im_addr, im_wdata, cpu_rst, busy, done, err, rx_ready} !==
        {1'b0, 10'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_vals: we=%b addr=%h wdata=%h cpu_rst=%b busy=%b done=%b err=%b rdy=%b required 0 000 00000000 1 1 0 0 1",
               im_we, im_addr, im_wdata, cpu_rst, busy, done, err, rx_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1 || cpu_rst !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle: rdy=%b cpu_rst=%b busy=%b required 1 1 1", rx_ready, cpu_rst, busy);
    end
  endtask

  task automatic test_basic_load();
    pulse_start();
    send_word(32'h0000_0002, 0);
    send_word(32'h1234_5678, 0);
    checks++;
    if (im_we !== 1'b1 || im_addr !== 10'd0 || im_wdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL first_write_timing: we=%b addr=%h data=%h required 1 000 12345678", im_we, im_addr, im_wdata);
    end
    send_word(32'h9ABC_DEF0, 0);
`ifdef BOOT_CHKSUM_EN
    checks++;
    if (done !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL chk_wait: done=%b rdy=%b required 0 1", done, rx_ready);
    end
    send_word(32'hACF1_3568, 0);
`endif
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || cpu_rst !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b err=%b cpu_rst=%b busy=%b required 1 0 1 0", done, err, cpu_rst, busy);
    end
    @(negedge clk);
    checks++;
    if (cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL basic_cpu_rst_fall: cpu_rst=%b required 0", cpu_rst);
    end
    checks++;
    if (wa.size() != 2 || wa[0] !== 10'd0 || wd[0] !== 32'h1234_5678 ||
        wa[1] !== 10'd1 || wd[1] !== 32'h9ABC_DEF0) begin
      errors++;
      $display("FAIL basic_writes: count=%0d required 2 at (0,12345678),(1,9abcdef0)", wa.size());
    end
`ifdef BOOT_CHKSUM_EN
    pulse_start();
    send_word(32'h0000_0002, 0);
    send_word(32'h1234_5678, 0);
    send_word(32'h9ABC_DEF0, 0);
    send_word(32'h0000_0000, 0);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL bad_chksum: err=%b done=%b cpu_rst=%b rdy=%b required 1 0 1 0", err, done, cpu_rst, rx_ready);
    end
`endif
  endtask

  task automatic test_oversize();
    pulse_start();
    send_word(32'h0000_0401, 0);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b0 || busy !== 1'b0 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL oversize_err: err=%b done=%b rdy=%b busy=%b cpu_rst=%b required 1 0 0 0 1",
               err, done, rx_ready, busy, cpu_rst);
    end
    @(negedge clk);
    checks++;
    if (wa.size() != 0) begin
      errors++;
      $display("FAIL oversize_no_write: writes=%0d required 0", wa.size());
    end
    pulse_start();
    send_word(32'h0000_0400, 0);
    checks++;
    if (err !== 1'b0 || rx_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL max_depth_accept: err=%b rdy=%b busy=%b required 0 1 1", err, rx_ready, busy);
    end
  endtask

  task automatic test_empty();
    pulse_start();
    send_word(32'h0000_0000, 0);
`ifdef BOOT_CHKSUM_EN
    send_word(32'h0000_0000, 0);
`endif
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL empty_done: done=%b err=%b required 1 0", done, err);
    end
    @(negedge clk);
    checks++;
    if (wa.size() != 0 || cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL empty_no_write: writes=%0d cpu_rst=%b required 0 0", wa.size(), cpu_rst);
    end
  endtask

  task automatic test_gaps();
    pulse_start();
    send_word(32'h0000_0002, 3);
    send_word(32'h1234_5678, 3);
    send_word(32'h9ABC_DEF0, 3);
`ifdef BOOT_CHKSUM_EN
    send_word(32'hACF1_3568, 3);
`endif
    @(negedge clk);
    checks++;
    if (wa.size() != 2 || wa[0] !== 10'd0 || wd[0] !== 32'h1234_5678 ||
        wa[1] !== 10'd1 || wd[1] !== 32'h9ABC_DEF0 || done !== 1'b1 || cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL gaps_writes: count=%0d done=%b cpu_rst=%b required 2 writes, 1 0", wa.size(), done, cpu_rst);
    end
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    #1;
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_not_ready: rdy=%b required 0", rx_ready);
    end
    repeat (6) @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wa.size() != 2 || done !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL done_ignores_rx: writes=%0d done=%b err=%b required 2 1 0", wa.size(), done, err);
    end
  endtask

  task automatic test_restart();
    pulse_start();
    send_word(32'h0000_0003, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hEE;
    #1;
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_blocks_rx: rdy=%b required 0", rx_ready);
    end
    @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b0;
    checks++;
    if (cpu_rst !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_state: cpu_rst=%b done=%b busy=%b required 1 0 1", cpu_rst, done, busy);
    end
    wa.delete();
    wd.delete();
    send_word(32'h0000_0001, 0);
    send_word(32'hCAFE_BABE, 0);
`ifdef BOOT_CHKSUM_EN
    send_word(32'hCAFE_BABE, 0);
`endif
    @(negedge clk);
    checks++;
    if (wa.size() != 1 || wa[0] !== 10'd0 || wd[0] !== 32'hCAFE_BABE || done !== 1'b1) begin
      errors++;
      $display("FAIL restart_write: count=%0d done=%b required 1 write (0,cafebabe), done 1", wa.size(), done);
    end
  endtask

  task automatic test_async_reset();
    pulse_start();
    send_word(32'h0000_0002, 0);
    send_word(32'h1111_2222, 0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({im_we, im_addr, im_wdata, cpu_rst, busy, done, err, rx_ready} !==
        {1'b0, 10'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: we=%b addr=%h wdata=%h cpu_rst=%b busy=%b done=%b err=%b rdy=%b required 0 000 00000000 1 1 0 0 1",
               im_we, im_addr, im_wdata, cpu_rst, busy, done, err, rx_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    wa.delete();
    wd.delete();
    send_word(32'h0000_0001, 0);
    send_word(32'hDEAD_BEEF, 0);
`ifdef BOOT_CHKSUM_EN
    send_word(32'hDEAD_BEEF, 0);
`endif
    @(negedge clk);
    checks++;
    if (wa.size() != 1 || wa[0] !== 10'd0 || wd[0] !== 32'hDEAD_BEEF || done !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_load: count=%0d done=%b required 1 write (0,deadbeef), done 1", wa.size(), done);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_oversize();
    test_empty();
    test_gaps();
    test_restart();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
